sdram_port_arbiter: RTL

- Shares the single SDRAM controller command port between the VGA framebuffer fetcher (burst reads) and the CPU data bus (single-word read/write).
- Sits between the CPU/VGA masters and the SDRAM controller inside `system`, in the 100 MHz SDRAM clock domain.
- VGA has priority as the real-time master. A run-length guard stops the CPU from being starved.

---
 rtl/sdram_port_arbiter_if.sv | 53 +++++
 rtl/sdram_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_port_arbiter_if : VGA/CPU request buses and SDRAM command port bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [15:0]       vga_rdata;
  logic              vga_rvalid;
  logic              vga_done;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic [1:0]        cpu_be;
  logic              cpu_gnt;
  logic [15:0]       cpu_rdata;
  logic              cpu_done;

  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_we;
  logic              mem_burst;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_dqm;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;
  logic              mem_done;

  // slave is the arbiter; master is everything around it (CPU, VGA, controller)
  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
           mem_cmd_ready, mem_rvalid, mem_rdata, mem_done,
    output vga_gnt, vga_rdata, vga_rvalid, vga_done,
           cpu_gnt, cpu_rdata, cpu_done,
           mem_cmd_valid, mem_we, mem_burst, mem_addr, mem_wdata, mem_dqm
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
           mem_cmd_ready, mem_rvalid, mem_rdata, mem_done,
    input  vga_gnt, vga_rdata, vga_rvalid, vga_done,
           cpu_gnt, cpu_rdata, cpu_done,
           mem_cmd_valid, mem_we, mem_burst, mem_addr, mem_wdata, mem_dqm
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_port_arbiter : shares one SDRAM command port between VGA and CPU
// Revision: 1.0
// ----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 8,
  parameter int MAX_VGA_RUN = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  sdram_port_arbiter_if.slave  bus
);

  localparam int c_run_w  = $clog2(MAX_VGA_RUN + 1);
  localparam int c_word_w = $clog2(BURST_LEN + 1);
  localparam logic [c_run_w-1:0]  c_run_max  = c_run_w'(MAX_VGA_RUN);
  localparam logic [c_word_w-1:0] c_word_max = c_word_w'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_grant_cpu;
  logic   w_grant_vga;

  logic                r_owner_vga;
  logic [c_run_w-1:0]  r_run;
  logic [c_word_w-1:0] r_words;

  logic                r_cmd_valid;
  logic                r_we;
  logic                r_burst;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [1:0]          r_dqm;

  logic                r_vga_gnt;
  logic [15:0]         r_vga_rdata;
  logic                r_vga_rvalid;
  logic                r_vga_done;
  logic                r_cpu_gnt;
  logic [15:0]         r_cpu_rdata;
  logic                r_cpu_done;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  // VGA wins unless it has already taken MAX_VGA_RUN grants while the CPU waited
  always_comb begin
    w_state_next = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_vga  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req && (!bus.vga_req || (r_run >= c_run_max))) begin
          w_grant_cpu  = 1'b1;
          w_state_next = ST_CMD;
        end else if (bus.vga_req) begin
          w_grant_vga  = 1'b1;
          w_state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (r_cmd_valid && bus.mem_cmd_ready) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_owner_vga  <= 1'b0;
      r_run        <= '0;
      r_words      <= '0;
      r_cmd_valid  <= 1'b0;
      r_we         <= 1'b0;
      r_burst      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_dqm        <= '0;
      r_vga_gnt    <= 1'b0;
      r_vga_rdata  <= '0;
      r_vga_rvalid <= 1'b0;
      r_vga_done   <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_done   <= 1'b0;
    end else begin
      r_vga_gnt    <= w_grant_vga;
      r_cpu_gnt    <= w_grant_cpu;
      r_vga_rvalid <= 1'b0;
      r_vga_done   <= 1'b0;
      r_cpu_done   <= 1'b0;

      if (w_grant_cpu) begin
        r_owner_vga <= 1'b0;
        r_cmd_valid <= 1'b1;
        r_we        <= bus.cpu_we;
        r_burst     <= 1'b0;
        r_addr      <= bus.cpu_addr;
        r_wdata     <= bus.cpu_wdata;
        r_dqm       <= ~bus.cpu_be;
        r_run       <= '0;
      end

      if (w_grant_vga) begin
        r_owner_vga <= 1'b1;
        r_cmd_valid <= 1'b1;
        r_we        <= 1'b0;
        r_burst     <= 1'b1;
        r_addr      <= bus.vga_addr;
        r_dqm       <= '0;
        if (!bus.cpu_req)            r_run <= '0;
        else if (r_run < c_run_max)  r_run <= r_run + 1'b1;
      end

      if ((r_state == ST_CMD) && r_cmd_valid && bus.mem_cmd_ready)
        r_cmd_valid <= 1'b0;

      // Controller strobes outside WAIT belong to no one and are dropped
      if (r_state == ST_WAIT) begin
        if (r_owner_vga) begin
          if (bus.mem_rvalid) begin
            r_vga_rvalid <= 1'b1;
            r_vga_rdata  <= bus.mem_rdata;
            if (r_words != c_word_max) r_words <= r_words + 1'b1;
          end
          if (bus.mem_done) begin
            r_vga_done <= 1'b1;
            r_words    <= '0;
          end
        end else begin
          if (bus.mem_rvalid && !r_we) r_cpu_rdata <= bus.mem_rdata;
          if (bus.mem_done)            r_cpu_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.vga_gnt       = r_vga_gnt;
  assign bus.vga_rdata     = r_vga_rdata;
  assign bus.vga_rvalid    = r_vga_rvalid;
  assign bus.vga_done      = r_vga_done;
  assign bus.cpu_gnt       = r_cpu_gnt;
  assign bus.cpu_rdata     = r_cpu_rdata;
  assign bus.cpu_done      = r_cpu_done;
  assign bus.mem_cmd_valid = r_cmd_valid;
  assign bus.mem_we        = r_we;
  assign bus.mem_burst     = r_burst;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_dqm       = r_dqm;

endmodule
`default_nettype wire
